add_num_operand_fetch: RTL
==========================

# add_num_operand_fetch

Operand-fetch stage for the add-two-numbers AFU. Given a host cache-line address, it issues one CCI-P c0 read request and waits for the matching response. It then extracts two 8-bit operands from the returned line and hands them downstream over a valid/ready handshake to the add/write stage. It sits between the MMIO address CSR and the adder.

## Interface

Parameters:
- OP_W, 8, operand width in bits
- A_LSB, 8, bit offset of operand A in the returned line (A = data[A_LSB+OP_W-1:A_LSB])
- B_LSB, 16, bit offset of operand B in the returned line
- TIMEOUT_CYCLES, 4096, maximum cycles to wait for a read response; legal range 2..65535

Ports:
- clk  in  1  single clock, pClk domain
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; begin a fetch
- start_addr  in  42  cache-line address, sampled with start
- busy  out  1  high in every state except IDLE
- c0_req_valid  out  1  read request valid, one-cycle pulse
- c0_req_addr  out  42  read address, eREQ_RDLINE_I, cl_len 1 line, vc_sel VA
- c0_req_mdata  out  16  request tag
- c0_tx_alm_full  in  1  c0 request channel almost full
- c0_rsp_valid  in  1  c0 read response valid
- c0_rsp_mdata  in  16  response tag
- c0_rsp_data  in  512  response line
- op_valid  out  1  operands valid
- op_ready  in  1  downstream accepts operands
- op_a  out  OP_W  operand A
- op_b  out  OP_W  operand B
- err_timeout  out  1  one-cycle pulse on response timeout

## Operation

- States: IDLE, REQ, WAIT_RSP, OUT.
- IDLE
  - start=1: latch start_addr and go to REQ.
  - start=0: stay in IDLE.
- REQ
  - c0_tx_alm_full=0: drive c0_req_valid=1 with the latched address and the current tag, clear the timeout counter, go to WAIT_RSP.
  - c0_tx_alm_full=1: stay in REQ with c0_req_valid=0. No timeout counting in REQ.
- WAIT_RSP
  - c0_rsp_valid=1 and c0_rsp_mdata equals the current tag: register op_a and op_b from the line, increment the tag (wraps 0xFFFF→0x0000), go to OUT.
  - c0_rsp_valid=1 with a non-matching tag: ignore it. This covers stale responses from timed-out requests.
  - Otherwise the timeout counter increments each cycle. When it reaches TIMEOUT_CYCLES-1 without a match: pulse err_timeout, increment the tag, go to IDLE. op_valid is never raised.
- OUT
  - op_valid=1 and op_a/op_b are held stable until op_ready=1.
  - On the op_valid && op_ready cycle, go to IDLE.
- start is ignored in every state except IDLE; no queueing.
- A matching response and the timeout terminal count in the same cycle: the response wins and err_timeout is not pulsed.
- Arithmetic:
  - Operands are raw bit slices, no sign handling.
  - Tag is a 16-bit modulo counter.
  - Timeout counter is 16 bits.

## Timing

- Reset (synchronous, active-high) applies on the next clk edge and forces the following:
  - State=IDLE.
  - busy=0, c0_req_valid=0, c0_req_addr=0, c0_req_mdata=0, op_valid=0, op_a=0, op_b=0, err_timeout=0.
  - Tag=0 and timeout counter=0.
- Reset mid-operation abandons the fetch. A response arriving after reset carries a tag that need not match and is ignored unless it equals the new tag 0. Software re-arms only after reset.
- All outputs are registered.
- start at edge N → busy=1 after N+1. If alm_full=0, c0_req_valid=1 for the single cycle after edge N+2.
- Response at edge M → op_valid=1 after edge M+1.
- Minimum latency is start-to-op_valid = 3 cycles plus the host response latency.
- c0_req_valid is never high for more than one consecutive cycle.
- err_timeout is high for exactly one cycle. busy drops in the same cycle that err_timeout rises.
- op_valid falls the cycle after handshake. A new start can be accepted on the cycle after op_valid falls.

## Test plan

- Basic fetch:
  - Stimulus: start with addr=0x1000, alm_full=0, tag 0. Respond 10 cycles later with mdata=0 and data[15:8]=0x05, data[23:16]=0x07, op_ready=1.
  - Required: exactly one request with addr 0x1000 and mdata 0; op_a=0x05, op_b=0x07; op_valid high for 1 cycle; busy returns to 0; next tag=1.
- Backpressure on request:
  - Stimulus: alm_full=1 for 20 cycles after start, then 0.
  - Required: no request during the stall; exactly one request on the first cycle alm_full=0; no err_timeout.
- Downstream stall:
  - Stimulus: response data A=0xFF, B=0x01, op_ready held 0 for 5 cycles.
  - Required: op_valid and operands stay stable for 5 cycles; IDLE on the cycle after op_ready=1; a start during OUT is ignored.
- Timeout and stale response:
  - Stimulus: TIMEOUT_CYCLES=16, no response. Then a second fetch; send the stale mdata=0 response, then mdata=1.
  - Required: err_timeout pulse 16 cycles after the request; the stale response is ignored; the second fetch completes with the mdata=1 data.
- Tag wrap:
  - Stimulus: preload 0xFFFF fetches (or force tag=0xFFFF), then run 2 fetches.
  - Required: mdata sequence 0xFFFF then 0x0000, both complete.
- Reset mid-operation:
  - Stimulus: assert reset for 1 cycle in WAIT_RSP.
  - Required: all outputs 0 on the next cycle, state IDLE, tag 0, a subsequent fetch succeeds.

Source files
------------

// File: rtl/add_num_operand_fetch.sv
// rtl/add_num_operand_fetch.sv - CCI-P c0 single-line operand fetch for the add-two-numbers AFU
module add_num_operand_fetch #(
    parameter int OP_W           = 8,
    parameter int A_LSB          = 8,
    parameter int B_LSB          = 16,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [41:0]     start_addr,
    output logic            busy,
    output logic            c0_req_valid,
    output logic [41:0]     c0_req_addr,
    output logic [15:0]     c0_req_mdata,
    input  logic            c0_tx_alm_full,
    input  logic            c0_rsp_valid,
    input  logic [15:0]     c0_rsp_mdata,
    input  logic [511:0]    c0_rsp_data,
    output logic            op_valid,
    input  logic            op_ready,
    output logic [OP_W-1:0] op_a,
    output logic [OP_W-1:0] op_b,
    output logic            err_timeout
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_OUT  = 2'd3;

    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [1:0]  state;
    logic [1:0]  state_next;
    logic [41:0] addr;
    logic [15:0] tag;
    logic [15:0] to_cnt;
    logic        rsp_match;
    logic        to_hit;
    logic        issue;

    // Only the operand slices of the line are consumed.
    logic unused_rsp_bits;
    assign unused_rsp_bits = ^c0_rsp_data;

    // A stale response from a timed-out request carries an older tag and never matches.
    assign rsp_match = c0_rsp_valid && (c0_rsp_mdata == tag);
    assign to_hit    = (to_cnt == TO_LAST);
    assign issue     = (state == S_REQ) && !c0_tx_alm_full;

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (start) state_next = S_REQ;
            S_REQ:  if (!c0_tx_alm_full) state_next = S_WAIT;
            S_WAIT: begin
                if (rsp_match) state_next = S_OUT;
                else if (to_hit) state_next = S_IDLE;
            end
            S_OUT:  if (op_ready) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            addr         <= '0;
            tag          <= '0;
            to_cnt       <= '0;
            busy         <= 1'b0;
            c0_req_valid <= 1'b0;
            c0_req_addr  <= '0;
            c0_req_mdata <= '0;
            op_valid     <= 1'b0;
            op_a         <= '0;
            op_b         <= '0;
            err_timeout  <= 1'b0;
        end else begin
            state        <= state_next;
            busy         <= (state_next != S_IDLE);
            op_valid     <= (state_next == S_OUT);
            c0_req_valid <= issue;
            err_timeout  <= (state == S_WAIT) && !rsp_match && to_hit;

            if (state == S_IDLE && start) begin
                addr <= start_addr;
            end

            if (issue) begin
                c0_req_addr  <= addr;
                c0_req_mdata <= tag;
                to_cnt       <= '0;
            end

            // Response wins over a timeout landing in the same cycle.
            if (state == S_WAIT) begin
                if (rsp_match) begin
                    op_a <= c0_rsp_data[A_LSB +: OP_W];
                    op_b <= c0_rsp_data[B_LSB +: OP_W];
                    tag  <= tag + 16'd1;
                end else if (to_hit) begin
                    tag  <= tag + 16'd1;
                end else begin
                    to_cnt <= to_cnt + 16'd1;
                end
            end
        end
    end

endmodule
